// File: rtl/sha256_pad.sv
// rtl/sha256_pad.sv - SHA-256 message padder and 64-cycle block sequencer (optional SHA256_PAD_BYPASS_EN)
module sha256_pad (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [31:0] m_data,
    input  logic        m_last,
    input  logic [1:0]  m_bytes,
`ifdef SHA256_PAD_BYPASS_EN
    input  logic        pad_bypass,
`endif
    input  logic        hash_done,
    output logic        w_vld,
    output logic [5:0]  w_cnt,
    output logic [31:0] w_data,
    output logic        w_first,
    output logic        w_final,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PAD,
        S_EMIT,
        S_WAIT,
        S_LEN
    } state_t;

    localparam logic [31:0] MARKER = 32'h8000_0000;

    state_t      state;
    logic [31:0] buffer [16];
    logic [63:0] bit_len;
    logic [3:0]  wi;
    logic [4:0]  pad_p;
    logic        mark_done;
    logic        first_pend;
    logic        final_pend;
    logic        len_pend;
    logic        mark_pend;

    logic        accept;
    logic        byp;
    logic        is_last;
    logic [2:0]  n_bytes;
    logic [3:0]  wi_eff;
    logic [31:0] word_in;
    logic [63:0] len_base;
    logic [63:0] len_add;

    always_comb begin
        accept   = m_valid & m_ready;
`ifdef SHA256_PAD_BYPASS_EN
        byp      = pad_bypass;
`else
        byp      = 1'b0;
`endif
        is_last  = m_last & ~byp;
        n_bytes  = (m_bytes == 2'd0) ? 3'd4 : {1'b0, m_bytes};
        wi_eff   = (state == S_IDLE) ? 4'd0 : wi;
        len_base = (state == S_IDLE) ? 64'd0 : bit_len;
        if (byp)
            len_add = 64'd0;
        else if (m_last)
            len_add = {58'd0, n_bytes, 3'b000};
        else
            len_add = 64'd32;
        // A short last word carries its own 0x80 marker right after the valid bytes.
        word_in = m_data;
        if (is_last) begin
            case (m_bytes)
                2'd1:    word_in = {m_data[31:24], 8'h80, 16'h0000};
                2'd2:    word_in = {m_data[31:16], 8'h80, 8'h00};
                2'd3:    word_in = {m_data[31:8], 8'h80};
                default: word_in = m_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            for (int i = 0; i < 16; i++) buffer[i] <= '0;
            bit_len    <= '0;
            wi         <= '0;
            pad_p      <= '0;
            mark_done  <= 1'b0;
            first_pend <= 1'b0;
            final_pend <= 1'b0;
            len_pend   <= 1'b0;
            mark_pend  <= 1'b0;
            m_ready    <= 1'b0;
            w_vld      <= 1'b0;
            w_cnt      <= '0;
            w_data     <= '0;
            w_first    <= 1'b0;
            w_final    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_FILL: begin
                    m_ready <= 1'b1;
                    if (accept) begin
                        buffer[wi_eff] <= word_in;
                        bit_len        <= len_base + len_add;
                        busy           <= 1'b1;
                        if (state == S_IDLE) begin
                            first_pend <= 1'b1;
                            final_pend <= 1'b0;
                            len_pend   <= 1'b0;
                            mark_pend  <= 1'b0;
                        end
                        if (is_last) begin
                            pad_p     <= (n_bytes == 3'd4) ? {1'b0, wi_eff} + 5'd1 : {1'b0, wi_eff};
                            mark_done <= (n_bytes != 3'd4);
                            m_ready   <= 1'b0;
                            state     <= S_PAD;
                        end else if (wi_eff == 4'd15) begin
                            // Full block: word 0 is already in the buffer, so the burst starts now.
                            final_pend <= byp & m_last;
                            w_vld      <= 1'b1;
                            w_cnt      <= '0;
                            w_data     <= buffer[0];
                            w_first    <= (state == S_IDLE) | first_pend;
                            w_final    <= byp & m_last;
                            wi         <= '0;
                            m_ready    <= 1'b0;
                            state      <= S_EMIT;
                        end else begin
                            wi    <= wi_eff + 4'd1;
                            state <= S_FILL;
                        end
                    end
                end
                S_PAD: begin
                    if (pad_p <= 5'd13) begin
                        if (!mark_done) buffer[pad_p[3:0]] <= MARKER;
                        buffer[14] <= bit_len[63:32];
                        buffer[15] <= bit_len[31:0];
                        final_pend <= 1'b1;
                        w_final    <= 1'b1;
                    end else if (pad_p <= 5'd15) begin
                        if (!mark_done) buffer[pad_p[3:0]] <= MARKER;
                        len_pend <= 1'b1;
                        w_final  <= 1'b0;
                    end else begin
                        len_pend  <= 1'b1;
                        mark_pend <= 1'b1;
                        w_final   <= 1'b0;
                    end
                    // Word 0 is never touched here: marker at p = 0 was written with the data.
                    w_vld   <= 1'b1;
                    w_cnt   <= '0;
                    w_data  <= buffer[0];
                    w_first <= first_pend;
                    wi      <= '0;
                    state   <= S_EMIT;
                end
                S_EMIT: begin
                    if (w_cnt == 6'd63) begin
                        for (int i = 0; i < 16; i++) buffer[i] <= '0;
                        w_vld      <= 1'b0;
                        w_cnt      <= '0;
                        w_data     <= '0;
                        w_first    <= 1'b0;
                        w_final    <= 1'b0;
                        first_pend <= 1'b0;
                        state      <= S_WAIT;
                    end else begin
                        w_cnt  <= w_cnt + 6'd1;
                        w_data <= (w_cnt < 6'd15) ? buffer[w_cnt[3:0] + 4'd1] : '0;
                    end
                end
                S_WAIT: begin
                    if (hash_done) begin
                        if (final_pend) begin
                            final_pend <= 1'b0;
                            len_pend   <= 1'b0;
                            mark_pend  <= 1'b0;
                            m_ready    <= 1'b1;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end else if (len_pend) begin
                            state <= S_LEN;
                        end else begin
                            m_ready <= 1'b1;
                            state   <= S_FILL;
                        end
                    end
                end
                S_LEN: begin
                    if (mark_pend) buffer[0] <= MARKER;
                    buffer[14] <= bit_len[63:32];
                    buffer[15] <= bit_len[31:0];
                    final_pend <= 1'b1;
                    len_pend   <= 1'b0;
                    mark_pend  <= 1'b0;
                    w_vld      <= 1'b1;
                    w_cnt      <= '0;
                    w_data     <= mark_pend ? MARKER : 32'd0;
                    w_first    <= first_pend;
                    w_final    <= 1'b1;
                    state      <= S_EMIT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_pad.sv
// tb/tb_sha256_pad.sv - self-checking bench for sha256_pad using a padding model and burst scoreboard
`timescale 1ns/1ps
module tb_sha256_pad;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_ready;
    logic [31:0] m_data = '0;
    logic        m_last = 1'b0;
    logic [1:0]  m_bytes = '0;
    logic        hash_done = 1'b0;
    logic        w_vld;
    logic [5:0]  w_cnt;
    logic [31:0] w_data;
    logic        w_first;
    logic        w_final;
    logic        busy;
`ifdef SHA256_PAD_BYPASS_EN
    logic        pad_bypass = 1'b0;
`endif

    always #5 clk = ~clk;

    sha256_pad dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_bytes   (m_bytes),
`ifdef SHA256_PAD_BYPASS_EN
        .pad_bypass(pad_bypass),
`endif
        .hash_done (hash_done),
        .w_vld     (w_vld),
        .w_cnt     (w_cnt),
        .w_data    (w_data),
        .w_first   (w_first),
        .w_final   (w_final),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] data;
        logic [5:0]  cnt;
        logic        first;
        logic        fin;
    } exp_t;

    typedef struct {
        int nbytes;
        int nblocks;
        int first_acc_lat;
        int last_done_lat;
    } case_t;

    exp_t         exp_q[$];
    byte unsigned msg[$];
    int passed = 0;
    int total  = 0;
    int cyc = 0;
    int acc_edge = 0;
    int done_edge = 0;
    int blocks_seen = 0;
    int first_rise_acc = -99;
    int last_rise_done = -99;
    int cd = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_valid && m_ready) acc_edge <= cyc + 1;
        if (hash_done) done_edge <= cyc + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && w_vld) begin
            if (w_cnt == 6'd0) begin
                if (blocks_seen == 0) first_rise_acc = cyc - acc_edge;
                last_rise_done = cyc - done_edge;
                blocks_seen++;
            end
            check(m_ready == 1'b0, "m_ready_low_during_burst", 64'(m_ready), 64'd0);
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_burst_word", 64'(w_cnt), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check(w_data == e.data && w_cnt == e.cnt && w_first == e.first && w_final == e.fin,
                      "burst_word", {16'd0, 2'b00, w_cnt, 6'd0, w_first, w_final, w_data},
                      {16'd0, 2'b00, e.cnt, 6'd0, e.first, e.fin, e.data});
            end
        end
    end

    // hash_done responder: a stray pulse mid-burst, then the real one 3 cycles after the burst.
    always @(negedge clk) begin
        hash_done = 1'b0;
        if (!reset_n) begin
            cd = 0;
        end else if (w_vld && w_cnt == 6'd20) begin
            hash_done = 1'b1;
        end else if (w_vld && w_cnt == 6'd63) begin
            cd = 3;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) hash_done = 1'b1;
        end
    end

    task automatic build_expected();
        byte unsigned p[$];
        logic [63:0]  bl;
        exp_t         e;
        int           nblk;
        p = msg;
        bl = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            for (int c = 0; c < 64; c++) begin
                if (c < 16)
                    e.data = {p[b*64+4*c], p[b*64+4*c+1], p[b*64+4*c+2], p[b*64+4*c+3]};
                else
                    e.data = 32'd0;
                e.cnt   = 6'(c);
                e.first = (b == 0);
                e.fin   = (b == nblk - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drive_word(input logic [31:0] w, input bit last, input logic [1:0] nb, output bit ok);
        int t = 0;
        @(negedge clk);
        m_valid = 1'b1;
        m_data  = w;
        m_last  = last;
        m_bytes = nb;
        while (!m_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        ok = (t < 1000);
        if (!ok) check(1'b0, "input_handshake_timeout", 64'(t), 64'd1000);
    endtask

    task automatic release_input();
        @(negedge clk);
        m_valid = 1'b0;
        m_last  = 1'b0;
`ifdef SHA256_PAD_BYPASS_EN
        pad_bypass = 1'b0;
`endif
    endtask

    task automatic send_msg();
        int nw;
        bit ok;
        logic [31:0] w;
        nw = (msg.size() + 3) / 4;
        for (int k = 0; k < nw; k++) begin
            w = $urandom();
            for (int j = 0; j < 4; j++)
                if (4*k + j < msg.size()) w[31-8*j -: 8] = msg[4*k+j];
            drive_word(w, k == nw - 1, 2'(msg.size() % 4), ok);
            if (!ok) break;
        end
        release_input();
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(t < 3000, "drain_timeout", 64'(t), 64'd3000);
    endtask

    task automatic load_abc();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        case_t tbl[13];
        int t;
        tbl[0]  = '{3,   1,  1, -1};
        tbl[1]  = '{1,   1,  1, -1};
        tbl[2]  = '{2,   1,  1, -1};
        tbl[3]  = '{4,   1,  1, -1};
        tbl[4]  = '{52,  1,  1, -1};
        tbl[5]  = '{55,  1,  1, -1};
        tbl[6]  = '{56,  2,  1,  1};
        tbl[7]  = '{57,  2,  1, -1};
        tbl[8]  = '{60,  2,  1,  1};
        tbl[9]  = '{64,  2, -1,  1};
        tbl[10] = '{65,  2,  0, -1};
        tbl[11] = '{119, 2,  0, -1};
        tbl[12] = '{120, 3,  0,  1};

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check(m_ready == 1'b0, "reset_m_ready", 64'(m_ready), 64'd0);
        check(w_vld == 1'b0 && w_cnt == 6'd0 && w_data == 32'd0, "reset_w_outputs",
              {25'd0, w_vld, w_cnt, w_data}, 64'd0);
        check(w_first == 1'b0 && w_final == 1'b0 && busy == 1'b0, "reset_flags",
              {61'd0, w_first, w_final, busy}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check(m_ready == 1'b1, "m_ready_after_release", 64'(m_ready), 64'd1);
        check(busy == 1'b0, "idle_not_busy", 64'(busy), 64'd0);

        foreach (tbl[i]) begin
            if (tbl[i].nbytes == 3) begin
                load_abc();
            end else begin
                msg.delete();
                for (int j = 0; j < tbl[i].nbytes; j++) msg.push_back(8'($urandom()));
            end
            blocks_seen = 0;
            build_expected();
            send_msg();
            wait_drain();
            check(blocks_seen == tbl[i].nblocks, $sformatf("block_count_len%0d", tbl[i].nbytes),
                  64'(blocks_seen), 64'(tbl[i].nblocks));
            if (tbl[i].first_acc_lat >= 0)
                check(first_rise_acc == tbl[i].first_acc_lat, $sformatf("first_burst_latency_len%0d", tbl[i].nbytes),
                      64'(first_rise_acc), 64'(tbl[i].first_acc_lat));
            if (tbl[i].last_done_lat >= 0)
                check(last_rise_done == tbl[i].last_done_lat, $sformatf("len_block_latency_len%0d", tbl[i].nbytes),
                      64'(last_rise_done), 64'(tbl[i].last_done_lat));
        end

        // Reset in the middle of a burst, then "abc" again must reproduce the same block.
        load_abc();
        blocks_seen = 0;
        build_expected();
        send_msg();
        t = 0;
        while (!(w_vld && w_cnt == 6'd30) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check(t < 500, "reach_cnt30_timeout", 64'(t), 64'd500);
        reset_n = 1'b0;
        #1;
        check(w_vld == 1'b0 && w_cnt == 6'd0 && busy == 1'b0, "reset_mid_burst",
              {56'd0, w_vld, w_cnt, busy}, 64'd0);
        check(m_ready == 1'b0, "reset_mid_burst_m_ready", 64'(m_ready), 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        load_abc();
        blocks_seen = 0;
        build_expected();
        send_msg();
        wait_drain();
        check(blocks_seen == 1, "abc_after_reset_blocks", 64'(blocks_seen), 64'd1);
        check(first_rise_acc == 1, "abc_after_reset_latency", 64'(first_rise_acc), 64'd1);

`ifdef SHA256_PAD_BYPASS_EN
        begin
            logic [31:0] pre[16];
            bit ok;
            load_abc();
            blocks_seen = 0;
            build_expected();
            for (int i = 0; i < 16; i++) pre[i] = exp_q[i].data;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                pad_bypass = 1'b1;
                drive_word(pre[i], (i == 15) || (i == 3), 2'($urandom()), ok);
                if (!ok) break;
            end
            release_input();
            wait_drain();
            check(blocks_seen == 1, "bypass_block_count", 64'(blocks_seen), 64'd1);
            check(first_rise_acc == 0, "bypass_latency", 64'(first_rise_acc), 64'd0);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sha256_pad.md
# sha256_pad

Message padder and block sequencer placed directly upstream of `sha256_main`. It accepts a big-endian 32-bit word stream with a last-word byte count and buffers each 512-bit block. It appends the SHA-256 padding (0x80 marker, zero fill, 64-bit bit length) and replays each block as a 64-cycle `w_vld`/`w_cnt`/`w_data` burst, then waits for `hash_done` before issuing the next block.

## Interface
- No parameters.
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `m_valid`  in  1  input word valid.
- `m_ready`  out  1  input word accepted when `m_valid & m_ready`.
- `m_data`  in  32  message word, first byte in [31:24].
- `m_last`  in  1  final word of message.
- `m_bytes`  in  2  valid bytes in the last word: 1..3 as given, 0 = 4. Ignored when `m_last` = 0.
- `hash_done`  in  1  one-cycle pulse from `sha256_main` marking block compression complete.
- `w_vld`  out  1  schedule word valid, high for 64 consecutive cycles per block.
- `w_cnt`  out  6  round index 0..63.
- `w_data`  out  32  buffer word `w_cnt` for `w_cnt` < 16; 0 otherwise.
- `w_first`  out  1  high with `w_vld` during the first block of a message.
- `w_final`  out  1  high with `w_vld` during the last block of a message.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Block buffer:** 16×32 words, cleared to zero when a block is emitted and on reset.
- **Bit-length counter:** 64 bits.
  - +32 per non-last word; +8·n for the last word (n = 4 when `m_bytes` = 0).
  - Wraps modulo 2^64 with no error.
  - Cleared on message start.
- **IDLE:** `m_ready` = 1. The first accepted word goes to FILL behaviour with word index `wi` = 0 and sets `first_pend`.
- **FILL:** `m_ready` = 1. Each accepted word is written at `wi`, then `wi++`.
  - Non-last write at `wi` = 15 → EMIT (full block); return to FILL after `hash_done`.
  - Last word with n < 4: bytes beyond n are replaced by 0x80 followed by zeros, in the same word. Marker position p = `wi`.
  - Last word with n = 4: marker goes to word p = `wi` + 1.
  - Then → PAD.
- **PAD (1 cycle):**
  - If p ≤ 13: write marker word (if not yet written) and length to words 14 (high) and 15 (low); set `final_pend`.
  - If p = 14 or 15: write marker only; set `len_pend`.
  - If p = 16: set `len_pend` and `mark_pend`.
  - → EMIT.
- **EMIT:** 64 cycles with `w_cnt` = 0..63.
  - `w_first` = `first_pend`; `w_final` = `final_pend`.
  - After `w_cnt` = 63, clear `first_pend` and go to WAIT.
- **WAIT:** wait for `hash_done`.
  - If `final_pend`: → IDLE.
  - Else if `len_pend`: → LEN.
  - Else: → FILL.
- **LEN (1 cycle):** buffer is zero. Write word 0 = 0x80000000 if `mark_pend`; write length to words 14/15; set `final_pend`; → EMIT.
- An empty message is unsupported: the minimum is 1 byte.
- `hash_done` outside WAIT is ignored.
- `m_valid` while `m_ready` = 0 is held off and no data is lost.

## Timing
- **Reset values:** `m_ready` = 0 during reset and 1 the first cycle after release. `w_vld`, `w_cnt`, `w_data`, `w_first`, `w_final`, `busy` = 0.
- All outputs are registered.
- **Last word accepted at cycle T:** PAD at T+1; `w_vld` rises at T+2 with `w_cnt` = 0; falls after T+65.
- **Full non-last block (word 15 at cycle T):** `w_vld` rises at T+1.
- **`hash_done` at cycle H:**
  - LEN at H+1, `w_vld` at H+2.
  - FILL resumes with `m_ready` = 1 at H+1.
  - IDLE `m_ready` = 1 at H+1.
- `w_cnt` increments by exactly 1 per cycle during EMIT. No gaps, no backpressure.
- **Reset mid-operation:** immediate return to IDLE. The burst is abandoned, the length counter and flags are cleared, and the buffer is zeroed.

## Configuration
- **`SHA256_PAD_BYPASS_EN` defined:** adds input port `pad_bypass` (1 bit, sampled with each accepted word).
  - Words with `pad_bypass` = 1 are treated as pre-padded blocks.
  - No marker or length is inserted, and the length counter does not advance.
  - A block completes at word 15. If `m_last` is also set on that word, `w_final` = 1 and the block returns to IDLE after `hash_done`.
  - `m_last` on any other bypass word is ignored.
- **Undefined:** port absent; padding is always applied.

## Test plan
- **"abc":** `m_data` = 0x61626300, `m_bytes` = 3, `m_last` → one block.
  - Word 0 = 0x61626380, words 1–14 = 0, word 15 = 0x00000018.
  - `w_first` = `w_final` = 1.
  - Downstream `s_data` = ba7816bf…f20015ad.
- **56-byte message (14 full words, last `m_bytes` = 0):**
  - Block 1: word 14 = 0x80000000, word 15 = 0.
  - After `hash_done`, block 2: words 0–13 = 0, word 14 = 0, word 15 = 0x000001C0, `w_final` = 1.
- **64-byte message:**
  - Block 1 emitted at T+1 after word 15 with `w_final` = 0.
  - Block 2: word 0 = 0x80000000, word 15 = 0x00000200.
- **Handshake/backpressure:** `m_valid` held high across a 2-block message → `m_ready` = 0 throughout EMIT/WAIT, and no word is dropped or duplicated. `hash_done` pulsed during EMIT → ignored.
- **Reset mid-burst:** assert `reset_n` = 0 at `w_cnt` = 30 → `w_vld` = 0 immediately. A new "abc" message after release reproduces the exact first-scenario block.
- **Bypass (with `SHA256_PAD_BYPASS_EN`):** 16 pre-padded "abc" words with `pad_bypass` = 1, last on word 15 → identical burst to the "abc" scenario, `w_final` = 1.
